dram_arbiter: RTL and testbench

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_bank.sv | 38 +++
 rtl/dram_arbiter.sv | 157 +++++++++++++++
 tb/tb_dram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared constants and helpers for the DRAM arbiter slice.
package dram_pkg;

   localparam int DEF_NUM_CORES = 4;
   localparam int DEF_ADDR_W    = 12;
   localparam int DEF_DATA_W    = 32;

   // Ceiling log2, for index widths (clog2(1) = 0).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

   // Port-index width, kept at least one bit wide for the single-core case.
   function automatic int idx_w(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage : dram_pkg

// File: rtl/dram_bank.sv
// Single-port synchronous RAM: write-first, one-cycle read latency.
// The array has no reset; contents persist across rst.
module dram_bank
   import dram_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Access the array on enable; a write also drives the new word onto the read port.
   // NOTE: non-blocking assignments for every flop, and the array is deliberately
   // left out of reset so it maps onto a real RAM macro.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
         end else begin
            rdata_q       <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule : dram_bank

// File: rtl/dram_arbiter.sv
// Multi-core arbiter in front of a single-port shared memory.
// Default build: round-robin arbitration with a rotating priority pointer.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
// The port list is identical in both builds.
module dram_arbiter
   import dram_pkg::*;
#(
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES-1:0]        we,
   input  logic [NUM_CORES*ADDR_W-1:0] addr,
   input  logic [NUM_CORES*DATA_W-1:0] wdata,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [NUM_CORES-1:0]        rvalid,
   output logic [NUM_CORES*DATA_W-1:0] rdata
);

   localparam int IDX_W = idx_w(NUM_CORES);
   typedef logic [IDX_W-1:0] idx_t;

   // Winner of the current cycle
   logic any_gnt;
   idx_t gnt_idx;

   // Memory access mux
   logic              bank_we;
   logic [ADDR_W-1:0] bank_addr;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] bank_rdata;

   // Read-return pipeline
   logic              rd_valid_q, rd_valid_d;
   idx_t              rd_port_q,  rd_port_d;
   logic [DATA_W-1:0] rdata_q [NUM_CORES];

`ifdef DRAM_ARB_FIXED_PRIO_EN

   // Fixed priority: scan from the top so the lowest requesting index is left as winner.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      if (!rst) begin
         for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
               any_gnt = 1'b1;
               gnt_idx = idx_t'(i);
            end
         end
      end
      if (any_gnt) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

`else

   idx_t ptr_q, ptr_d;
   idx_t cand;

   // Round-robin: search upward from ptr modulo NUM_CORES; winner+1 becomes the new ptr.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      cand    = '0;
      ptr_d   = ptr_q;
      if (!rst) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            cand = idx_t'((int'(ptr_q) + i) % NUM_CORES);
            if (!any_gnt && req[cand]) begin
               any_gnt = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (any_gnt) begin
         gnt[gnt_idx] = 1'b1;
         ptr_d        = idx_t'((int'(gnt_idx) + 1) % NUM_CORES);
      end
   end

   // Priority pointer register; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

`endif

   // Steer the granted port's command to the bank; gnt is already zero during rst.
   always_comb begin
      bank_we    = any_gnt & we[gnt_idx];
      bank_addr  = addr[int'(gnt_idx) * ADDR_W +: ADDR_W];
      bank_wdata = wdata[int'(gnt_idx) * DATA_W +: DATA_W];
      rd_valid_d = any_gnt & ~we[gnt_idx];
      rd_port_d  = gnt_idx;
   end

   dram_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bank (
      .clk     (clk),
      .en_i    (any_gnt),
      .we_i    (bank_we),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata)
   );

   // Track which port owns the read word arriving from the bank next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_port_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_port_q  <= rd_port_d;
      end
   end

   // Hold each port's last read word so rdata stays stable between its rvalid pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            rdata_q[i] <= '0;
         end
      end else if (rd_valid_q) begin
         rdata_q[rd_port_q] <= bank_rdata;
      end
   end

   // Present the bank word on the owning port in the return cycle; a read in
   // flight when rst rises is dropped rather than reported.
   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         rdata[i*DATA_W +: DATA_W] = rdata_q[i];
      end
      if (rd_valid_q && !rst) begin
         rvalid[rd_port_q]                            = 1'b1;
         rdata[int'(rd_port_q) * DATA_W +: DATA_W] = bank_rdata;
      end
   end

endmodule : dram_arbiter

// File: tb/tb_dram_arbiter.sv
// Directed, table-driven bench for dram_arbiter (4 cores, 12-bit addr, 32-bit data).
// Expectations follow the build: round-robin by default, fixed priority
// when DRAM_ARB_FIXED_PRIO_EN is defined.
module tb_dram_arbiter;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 32;

   localparam logic [31:0] Z  = 32'h0000_0000;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] W5 = 32'h0000_0005;
   localparam logic [31:0] C2 = 32'h2222_2222;
   localparam logic [31:0] A0 = 32'hA0A0_A0A0;
   localparam logic [31:0] A1 = 32'hA1A1_A1A1;
   localparam logic [31:0] A2 = 32'hA2A2_A2A2;
   localparam logic [31:0] A3 = 32'hA3A3_A3A3;
   localparam logic [47:0] ARD = {12'h103, 12'h102, 12'h101, 12'h100};

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req, we, gnt, rvalid;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata, rdata;

   always #5 clk = ~clk;

   dram_arbiter #(
      .NUM_CORES (N),
      .ADDR_W    (AW),
      .DATA_W    (DW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .wdata  (wdata),
      .gnt    (gnt),
      .rvalid (rvalid),
      .rdata  (rdata)
   );

   typedef struct {
      logic         rst;
      logic [3:0]   req;
      logic [3:0]   we;
      logic [47:0]  addr;
      logic [127:0] wdata;
      logic [3:0]   gnt;
      logic [3:0]   rvalid;
      logic [127:0] rdata;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cnt [N];

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] w,
                      input logic [47:0] a, input logic [127:0] d,
                      input logic [3:0] g, input logic [3:0] rv, input logic [127:0] rd);
      vec_t v;
      v.rst = r; v.req = rq; v.we = w; v.addr = a; v.wdata = d;
      v.gnt = g; v.rvalid = rv; v.rdata = rd;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      rst   = 1'b1;
      req   = '0;
      we    = '0;
      addr  = ARD;
      wdata = '0;

      // Reset, then port 2 writes DEADBEEF to 0x010 and port 0 reads it back.
      add(1, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, '0);
      add(0, 4'b0100, 4'b0100, {12'h000, 12'h010, 12'h000, 12'h000}, {Z, DB, Z, Z},
          4'b0100, 4'b0000, '0);
      add(0, 4'b0001, 4'b0000, {12'h000, 12'h000, 12'h000, 12'h010}, '0,
          4'b0001, 4'b0000, '0);
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {Z, Z, Z, DB});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, {Z, Z, Z, DB});
      // Port 1 writes 5 to 0x020, port 3 reads it the very next cycle.
      add(0, 4'b0010, 4'b0010, {12'h000, 12'h000, 12'h020, 12'h000}, {Z, Z, W5, Z},
          4'b0010, 4'b0000, {Z, Z, Z, DB});
      add(0, 4'b1000, 4'b0000, {12'h020, 12'h000, 12'h000, 12'h000}, '0,
          4'b1000, 4'b0000, {Z, Z, Z, DB});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b1000, {W5, Z, Z, DB});
      // Preload 0x100..0x103 and 0x030.
      add(0, 4'b0001, 4'b0001, ARD, {Z, Z, Z, A0}, 4'b0001, 4'b0000, {W5, Z, Z, DB});
      add(0, 4'b0010, 4'b0010, ARD, {Z, Z, A1, Z}, 4'b0010, 4'b0000, {W5, Z, Z, DB});
      add(0, 4'b0100, 4'b0100, ARD, {Z, A2, Z, Z}, 4'b0100, 4'b0000, {W5, Z, Z, DB});
      add(0, 4'b1000, 4'b1000, ARD, {A3, Z, Z, Z}, 4'b1000, 4'b0000, {W5, Z, Z, DB});
      add(0, 4'b0001, 4'b0001, {12'h000, 12'h000, 12'h000, 12'h030}, {Z, Z, Z, C2},
          4'b0001, 4'b0000, {W5, Z, Z, DB});
      // Writes attempted under rst: no grant and memory untouched.
      add(1, 4'b1111, 4'b1111, {4{12'h030}}, {4{32'h1111_1111}},
          4'b0000, 4'b0000, {W5, Z, Z, DB});
      add(1, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, '0);
      add(0, 4'b0100, 4'b0000, {12'h000, 12'h030, 12'h000, 12'h000}, '0,
          4'b0100, 4'b0000, '0);
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0100, {Z, C2, Z, Z});
      // Port 2 write withdrawn before grant while port 0 holds a read.
      add(0, 4'b0101, 4'b0100, {12'h000, 12'h102, 12'h000, 12'h101}, {Z, 32'hFFFF_FFFF, Z, Z},
          4'b0001, 4'b0000, {Z, C2, Z, Z});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {Z, C2, Z, A1});
      add(0, 4'b0010, 4'b0000, {12'h000, 12'h000, 12'h102, 12'h000}, '0,
          4'b0010, 4'b0000, {Z, C2, Z, A1});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0010, {Z, C2, A2, A1});
      // Back-to-back reads by port 1, then rst kills the second return.
      add(0, 4'b0010, 4'b0000, {12'h000, 12'h000, 12'h100, 12'h000}, '0,
          4'b0010, 4'b0000, {Z, C2, A2, A1});
      add(0, 4'b0010, 4'b0000, {12'h000, 12'h000, 12'h103, 12'h000}, '0,
          4'b0010, 4'b0010, {Z, C2, A0, A1});
      add(1, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, {Z, C2, A0, A1});
      add(1, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, '0);
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0001, 4'b0000, '0);
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {Z, Z, Z, A0});
      add(1, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0000, {Z, Z, Z, A0});
`ifdef DRAM_ARB_FIXED_PRIO_EN
      // All requesting: port 0 always wins; then ports 0 and 3 contend.
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0001, 4'b0000, '0);
      for (int k = 0; k < 4; k++) begin
         add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0001, 4'b0001, {Z, Z, Z, A0});
      end
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {Z, Z, Z, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b0001, 4'b0000, {Z, Z, Z, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b0001, 4'b0001, {Z, Z, Z, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b0001, 4'b0001, {Z, Z, Z, A0});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {Z, Z, Z, A0});
`else
      // All requesting from reset: grants 0,1,2,3,0; then ports 0 and 3 alternate.
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0001, 4'b0000, '0);
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0010, 4'b0001, {Z, Z, Z, A0});
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0100, 4'b0010, {Z, Z, A1, A0});
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b1000, 4'b0100, {Z, A2, A1, A0});
      add(0, 4'b1111, 4'b0000, ARD, '0, 4'b0001, 4'b1000, {A3, A2, A1, A0});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b0001, {A3, A2, A1, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b1000, 4'b0000, {A3, A2, A1, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b0001, 4'b1000, {A3, A2, A1, A0});
      add(0, 4'b1001, 4'b0000, ARD, '0, 4'b1000, 4'b0001, {A3, A2, A1, A0});
      add(0, 4'b0000, 4'b0000, ARD, '0, 4'b0000, 4'b1000, {A3, A2, A1, A0});
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst   = tbl[i].rst;
         req   = tbl[i].req;
         we    = tbl[i].we;
         addr  = tbl[i].addr;
         wdata = tbl[i].wdata;
         #2;
         check($sformatf("v%0d gnt", i),    128'(gnt),    128'(tbl[i].gnt));
         check($sformatf("v%0d rvalid", i), 128'(rvalid), 128'(tbl[i].rvalid));
         check($sformatf("v%0d rdata", i),  rdata,        tbl[i].rdata);
      end

      // Fairness window: all ports requesting for 2*N cycles, count grants per port.
      for (int p = 0; p < N; p++) cnt[p] = 0;
      for (int c = 0; c < 2 * N; c++) begin
         @(negedge clk);
         rst  = 1'b0;
         req  = 4'b1111;
         we   = 4'b0000;
         addr = ARD;
         #2;
         for (int p = 0; p < N; p++) begin
            if (gnt[p]) cnt[p]++;
         end
      end
      @(negedge clk);
      req = '0;
      for (int p = 0; p < N; p++) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
         check($sformatf("grant count port %0d", p), 128'(cnt[p]), (p == 0) ? 128'(2 * N) : 128'(0));
`else
         check($sformatf("grant count port %0d", p), 128'(cnt[p]), 128'(2));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_dram_arbiter
